// File: rtl/fix_trailer_check.sv
// Streaming FIX trailer checker: sums message bytes up to the SOH before "10=" and compares with the parsed value.
// Defining FIX_TRAILER_STATS_EN adds saturating good/bad message counters (good_cnt_o, bad_cnt_o).
module fix_trailer_check #(
    parameter logic [7:0]  SOH     = 8'h01,
    parameter int unsigned MAX_LEN = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        sof_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ok_o,
    output logic [1:0]  err_code_o,
    output logic [7:0]  calc_sum_o,
    output logic [7:0]  rx_sum_o
`ifdef FIX_TRAILER_STATS_EN
    ,
    output logic [15:0] good_cnt_o,
    output logic [15:0] bad_cnt_o
`endif
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
    localparam int unsigned VAL_W = 10;
    localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_FORMAT   = 2'd2;
    localparam logic [1:0] ERR_LEN      = 2'd3;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_EQ = 8'h3D;

    typedef enum logic [3:0] {
        S_IDLE, S_BODY, S_T1, S_T0, S_EQ, S_D1, S_D2, S_D3, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         snap_q, snap_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               after_soh_q, after_soh_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ok_q, ok_d;
    logic [1:0]         err_q, err_d;
    logic [7:0]         calc_q, calc_d;
    logic [7:0]         rx_q, rx_d;

    logic               fin_c;
    logic [1:0]         code_c;
    logic               is_digit_c;
    logic [3:0]         digit_c;
    logic [LEN_W-1:0]   len_inc_c;

    assign is_digit_c = (data_i >= CH_0) && (data_i <= CH_9);
    assign digit_c    = 4'(data_i - CH_0);
    assign len_inc_c  = len_q + LEN_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update; fin_c/code_c flag a result on this byte
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        snap_d      = snap_q;
        val_d       = val_q;
        len_d       = len_q;
        after_soh_d = after_soh_q;
        fin_c       = 1'b0;
        code_c      = ERR_NONE;

        if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end

        if (valid_i && sof_i) begin
            // A sof byte always starts a fresh message, abandoning any in flight
            state_d     = S_BODY;
            sum_d       = data_i;
            snap_d      = '0;
            val_d       = '0;
            len_d       = LEN_W'(1);
            after_soh_d = 1'b0;
        end else if (valid_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            sum_d = sum_q + data_i;
            len_d = len_inc_c;
            case (state_q)
                S_BODY, S_T1, S_T0: begin
                    state_d     = S_BODY;
                    after_soh_d = 1'b0;
                    if (data_i == SOH) begin
                        snap_d      = sum_q + data_i;
                        after_soh_d = 1'b1;
                    end else if ((state_q == S_BODY) && after_soh_q && (data_i == CH_1)) begin
                        state_d = S_T1;
                    end else if ((state_q == S_T1) && (data_i == CH_0)) begin
                        state_d = S_T0;
                    end else if ((state_q == S_T0) && (data_i == CH_EQ)) begin
                        state_d = S_EQ;
                        val_d   = '0;
                    end
                end
                S_EQ, S_D1, S_D2: begin
                    val_d = val_q * VAL_W'(10) + VAL_W'(digit_c);
                    if (!is_digit_c || (val_d > VAL_W'(255))) begin
                        state_d = S_DONE;
                        fin_c   = 1'b1;
                        code_c  = ERR_FORMAT;
                    end else if (state_q == S_EQ) begin
                        state_d = S_D1;
                    end else if (state_q == S_D1) begin
                        state_d = S_D2;
                    end else begin
                        state_d = S_D3;
                    end
                end
                S_D3: begin
                    state_d = S_DONE;
                    fin_c   = 1'b1;
                    if (data_i != SOH) begin
                        code_c = ERR_FORMAT;
                    end else if (val_q[7:0] != snap_q) begin
                        code_c = ERR_MISMATCH;
                    end
                end
                default: begin
                end
            endcase
            // Overlength outranks any other outcome of the same byte
            if (len_inc_c > LEN_LIMIT) begin
                state_d = S_DONE;
                fin_c   = 1'b1;
                code_c  = ERR_LEN;
            end
        end
    end

    // Output decode, registered below
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = fin_c;
        ok_d   = fin_c && (code_c == ERR_NONE);
        err_d  = fin_c ? code_c : ERR_NONE;
        calc_d = fin_c ? snap_d : calc_q;
        rx_d   = fin_c ? val_d[7:0] : rx_q;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q       <= '0;
            snap_q      <= '0;
            val_q       <= '0;
            len_q       <= '0;
            after_soh_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= ERR_NONE;
            calc_q      <= '0;
            rx_q        <= '0;
        end else begin
            sum_q       <= sum_d;
            snap_q      <= snap_d;
            val_q       <= val_d;
            len_q       <= len_d;
            after_soh_q <= after_soh_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            calc_q      <= calc_d;
            rx_q        <= rx_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign ok_o       = ok_q;
    assign err_code_o = err_q;
    assign calc_sum_o = calc_q;
    assign rx_sum_o   = rx_q;

`ifdef FIX_TRAILER_STATS_EN
    logic [15:0] good_q;
    logic [15:0] bad_q;

    // Saturating result counters; abandoned messages never raise fin_c
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (fin_c) begin
            if (ok_d) begin
                if (good_q != 16'hFFFF) begin
                    good_q <= good_q + 16'd1;
                end
            end else begin
                if (bad_q != 16'hFFFF) begin
                    bad_q <= bad_q + 16'd1;
                end
            end
        end
    end

    assign good_cnt_o = good_q;
    assign bad_cnt_o  = bad_q;
`endif

endmodule

// File: tb/tb_fix_trailer_check.sv
// Directed bench for fix_trailer_check: vector table plus hand sequences for restart, reset and length limits.
module tb_fix_trailer_check;

    localparam logic [7:0] SOH_B = 8'h01;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       sof;

    logic       busy_o, done_o, ok_o;
    logic [1:0] err_code_o;
    logic [7:0] calc_sum_o, rx_sum_o;

    logic       busy8, done8, ok8;
    logic [1:0] err8;
    logic [7:0] calc8, rx8;

`ifdef FIX_TRAILER_STATS_EN
    logic [15:0] good_cnt, bad_cnt, good_cnt8, bad_cnt8;
`endif

    fix_trailer_check dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data),
        .valid_i    (valid),
        .sof_i      (sof),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ok_o       (ok_o),
        .err_code_o (err_code_o),
        .calc_sum_o (calc_sum_o),
        .rx_sum_o   (rx_sum_o)
`ifdef FIX_TRAILER_STATS_EN
        ,
        .good_cnt_o (good_cnt),
        .bad_cnt_o  (bad_cnt)
`endif
    );

    fix_trailer_check #(.MAX_LEN(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data),
        .valid_i    (valid),
        .sof_i      (sof),
        .busy_o     (busy8),
        .done_o     (done8),
        .ok_o       (ok8),
        .err_code_o (err8),
        .calc_sum_o (calc8),
        .rx_sum_o   (rx8)
`ifdef FIX_TRAILER_STATS_EN
        ,
        .good_cnt_o (good_cnt8),
        .bad_cnt_o  (bad_cnt8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0][7:0] b;
        logic [4:0]       n;
        logic             ok;
        logic [1:0]       err;
        logic [7:0]       calc;
        logic [7:0]       rx;
        logic             chk_sums;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Done-pulse monitor on the default instance
    int         pulse_cnt = 0;
    logic [1:0] mon_err   = 2'd0;
    logic       mon_ok    = 1'b0;
    logic [7:0] mon_calc  = 8'd0;

    always @(negedge clk) begin
        if (done_o) begin
            pulse_cnt <= pulse_cnt + 1;
            mon_err   <= err_code_o;
            mon_ok    <= ok_o;
            mon_calc  <= calc_sum_o;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string s, input logic ok, input logic [1:0] err,
                                input logic [7:0] calc, input logic [7:0] rx, input logic cs);
        vec_t v;
        v = '0;
        for (int i = 0; i < s.len(); i++) begin
            v.b[i] = (s[i] == "|") ? SOH_B : s[i];
        end
        v.n        = 5'(s.len());
        v.ok       = ok;
        v.err      = err;
        v.calc     = calc;
        v.rx       = rx;
        v.chk_sums = cs;
        return v;
    endfunction

    // Drive one input cycle starting at a falling edge, return at the next falling edge
    task automatic put(input logic [7:0] b, input logic s, input logic v);
        data  = b;
        sof   = s;
        valid = v;
        @(negedge clk);
    endtask

    task automatic send_bytes(input vec_t v, output logic early);
        early = 1'b0;
        for (int i = 0; i < int'(v.n); i++) begin
            if (i > 0) early = early | done_o;
            put(v.b[i], (i == 0), 1'b1);
        end
    endtask

    task automatic check_result(input vec_t v, input string tag, input logic early);
        chk({tag, "_early_done"}, int'(early), 0);
        chk({tag, "_done"}, int'(done_o), 1);
        chk({tag, "_ok"}, int'(ok_o), int'(v.ok));
        chk({tag, "_err"}, int'(err_code_o), int'(v.err));
        if (v.chk_sums) begin
            chk({tag, "_calc"}, int'(calc_sum_o), int'(v.calc));
            chk({tag, "_rx"}, int'(rx_sum_o), int'(v.rx));
        end
    endtask

    vec_t tbl[7];

    initial begin
        logic early;
        vec_t v;
        int   c0;

        tbl[0] = mk("8=A|10=183|",        1'b1, 2'd0, 8'd183, 8'd183, 1'b1);
        tbl[1] = mk("8=A|10=184|",        1'b0, 2'd1, 8'd183, 8'd184, 1'b1);
        tbl[2] = mk("8=A|10=18A",         1'b0, 2'd2, 8'd0,   8'd0,   1'b0);
        tbl[3] = mk("8=A|110=5|10=188|",  1'b1, 2'd0, 8'd188, 8'd188, 1'b1);
        tbl[4] = mk("8=AB|10=249|",       1'b1, 2'd0, 8'd249, 8'd249, 1'b1);
        tbl[5] = mk("8=A|10=1X",          1'b0, 2'd2, 8'd0,   8'd0,   1'b0);
        tbl[6] = mk("8=A|10=X",           1'b0, 2'd2, 8'd0,   8'd0,   1'b0);

        rst   = 1'b0;
        data  = 8'd0;
        valid = 1'b0;
        sof   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_ok", int'(ok_o), 0);
        chk("rst_err", int'(err_code_o), 0);
        chk("rst_calc", int'(calc_sum_o), 0);
        chk("rst_rx", int'(rx_sum_o), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send_bytes(tbl[i], early);
            check_result(tbl[i], $sformatf("vec%0d", i), early);
            put(8'd0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_pulse_len", i), int'(done_o), 0);
            put(8'd0, 1'b0, 1'b0);
        end

        // Back-to-back: next sof lands in the cycle done_o is high
        send_bytes(tbl[0], early);
        check_result(tbl[0], "b2b_first", early);
        send_bytes(tbl[4], early);
        check_result(tbl[4], "b2b_second", early);
        put(8'd0, 1'b0, 1'b0);
        put(8'd0, 1'b0, 1'b0);

        // Stalled partial message abandoned by a new sof
        c0 = pulse_cnt;
        put("8", 1'b1, 1'b1);
        put(8'd0, 1'b0, 1'b0);
        put("=", 1'b0, 1'b1);
        put(8'd0, 1'b0, 1'b0);
        put(8'd0, 1'b0, 1'b0);
        put("A", 1'b0, 1'b1);
        put(SOH_B, 1'b0, 1'b1);
        put(8'd0, 1'b0, 1'b0);
        put("1", 1'b0, 1'b1);
        send_bytes(tbl[0], early);
        check_result(tbl[0], "restart", early);
        put(8'd0, 1'b0, 1'b0);
        put(8'd0, 1'b0, 1'b0);
        chk("restart_pulses", pulse_cnt - c0, 1);
        chk("restart_mon_ok", int'(mon_ok), 1);
        chk("restart_mon_calc", int'(mon_calc), 183);

        // Trailer value above 255
        c0 = pulse_cnt;
        v  = mk("8=A|10=256|", 1'b0, 2'd2, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < int'(v.n); i++) put(v.b[i], (i == 0), 1'b1);
        repeat (3) put(8'd0, 1'b0, 1'b0);
        chk("over255_pulses", pulse_cnt - c0, 1);
        chk("over255_err", int'(mon_err), 2);
        chk("over255_ok", int'(mon_ok), 0);

        // Length limit on the MAX_LEN=8 instance: 8 bytes fine, 9th overflows
        v = mk("8=AAAAAAA", 1'b0, 2'd3, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < int'(v.n); i++) begin
            put(v.b[i], (i == 0), 1'b1);
            if (i == 7) chk("len_at_max_no_done", int'(done8), 0);
        end
        chk("len_over_done", int'(done8), 1);
        chk("len_over_err", int'(err8), 3);
        chk("len_over_ok", int'(ok8), 0);
        put(8'd0, 1'b0, 1'b0);
        put(8'd0, 1'b0, 1'b0);

        // Length and format error on the same byte: length wins
        v = mk("8=A|10=2X", 1'b0, 2'd3, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < int'(v.n); i++) begin
            put(v.b[i], (i == 0), 1'b1);
            if (i == 7) chk("prio_at_max_no_done", int'(done8), 0);
        end
        chk("prio_done", int'(done8), 1);
        chk("prio_err", int'(err8), 3);
        put(8'd0, 1'b0, 1'b0);
        put(8'd0, 1'b0, 1'b0);

        // Reset in the middle of a trailer
        v = mk("8=A|10=1", 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < int'(v.n); i++) put(v.b[i], (i == 0), 1'b1);
        valid = 1'b0;
        sof   = 1'b0;
        chk("mid_busy", int'(busy_o), 1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        chk("midrst_ok", int'(ok_o), 0);
        chk("midrst_err", int'(err_code_o), 0);
        chk("midrst_calc", int'(calc_sum_o), 0);
        chk("midrst_rx", int'(rx_sum_o), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_bytes(tbl[0], early);
        check_result(tbl[0], "after_rst", early);
        put(8'd0, 1'b0, 1'b0);
        put(8'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
